// File: rtl/ula_serial_n_bits.sv
// ula_serial_n_bits -- bit-slice serial ALU (74181-style function set).
// A request is captured in IDLE, then evaluated SLICE_W bits per cycle,
// LSB slice first, with the carry chained through r_carry. The result and
// flags are published on entry to DONE. They stay there until the next
// result is published or reset clears them.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   request handshake (a, b, s, m, c_in)
//   out_valid / out_ready result handshake (f, c_out, overflow, a_eq_b)
//   busy                  high while an operation is in CALC or DONE
//
// state | meaning
// IDLE  | waiting for a request, in_ready=1
// CALC  | one slice evaluated per cycle
// DONE  | result presented, waiting for out_ready
module ula_serial_n_bits #(
   parameter int WIDTH   = 16,
   parameter int SLICE_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       s,
   input  logic             m,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] f,
   output logic             c_out,
   output logic             overflow,
   output logic             a_eq_b,
   output logic             busy
);

   localparam int NSLICE = WIDTH / SLICE_W;
   localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} state_t;

   state_t             r_state;
   logic [WIDTH-1:0]   r_a, r_b, r_acc, r_f;
   logic [3:0]         r_s;
   logic               r_m, r_carry;
   logic [CW-1:0]      r_cnt;
   logic               r_in_ready, r_out_valid, r_busy;
   logic               r_c_out, r_ovf, r_eq;

   logic [SLICE_W-1:0] w_as, w_bs, w_x, w_y, w_lgc, w_slice;
   logic [SLICE_W:0]   w_sum;
   logic [WIDTH-1:0]   w_slice_ext, w_acc_next;
   logic               w_inv, w_c_out, w_ovf;

   // Operands are shifted right each cycle, so the active slice is always
   // at the bottom; on the last slice it holds the operand MSBs.
   assign w_as = r_a[SLICE_W-1:0];
   assign w_bs = r_b[SLICE_W-1:0];

   always_comb begin
      w_x   = '0;
      w_y   = '0;
      w_lgc = '0;
      case (r_s)
         4'h0: begin w_lgc = ~w_as;          w_x = w_as;          w_y = '1;          end
         4'h1: begin w_lgc = ~(w_as | w_bs); w_x = w_as;          w_y = w_as | w_bs; end
         4'h2: begin w_lgc = ~w_as & w_bs;   w_x = w_as | w_bs;   w_y = '1;          end
         4'h3: begin w_lgc = '0;             w_x = '1;            w_y = '0;          end
         4'h4: begin w_lgc = ~(w_as & w_bs); w_x = w_as;          w_y = w_as & w_bs; end
         4'h5: begin w_lgc = ~w_bs;          w_x = w_as | w_bs;   w_y = w_as & w_bs; end
         4'h6: begin w_lgc = w_as ^ w_bs;    w_x = w_as;          w_y = ~w_bs;       end
         4'h7: begin w_lgc = w_as & ~w_bs;   w_x = w_as & ~w_bs;  w_y = '1;          end
         4'h8: begin w_lgc = w_as & w_bs;    w_x = w_as;          w_y = w_as & ~w_bs; end
         4'h9: begin w_lgc = ~(w_as ^ w_bs); w_x = w_as;          w_y = w_bs;        end
         4'hA: begin w_lgc = w_bs;           w_x = w_as | ~w_bs;  w_y = w_as & w_bs; end
         4'hB: begin w_lgc = ~w_as | w_bs;   w_x = w_as & w_bs;   w_y = '1;          end
         4'hC: begin w_lgc = '1;             w_x = w_as;          w_y = w_as;        end
         4'hD: begin w_lgc = w_as | ~w_bs;   w_x = w_as | w_bs;   w_y = w_as;        end
         4'hE: begin w_lgc = w_as | w_bs;    w_x = w_as | ~w_bs;  w_y = w_as;        end
         default: begin w_lgc = w_as;        w_x = w_as;          w_y = '0;          end
      endcase
   end

   assign w_sum       = {1'b0, w_x} + {1'b0, w_y} + {{SLICE_W{1'b0}}, r_carry};
   assign w_slice     = r_m ? w_lgc : w_sum[SLICE_W-1:0];
   assign w_slice_ext = WIDTH'(w_slice);
   // Result fills from the top and shifts down; after NSLICE steps it is aligned.
   assign w_acc_next  = (r_acc >> SLICE_W) | (w_slice_ext << (WIDTH - SLICE_W));

   // Functions whose arithmetic form is a subtraction report borrow-style carry.
   assign w_inv   = (r_s == 4'h0) || (r_s == 4'h2) || (r_s == 4'h3) ||
                    (r_s == 4'h6) || (r_s == 4'h7) || (r_s == 4'hB);
   assign w_c_out = r_m ? 1'b0 : (w_sum[SLICE_W] ^ w_inv);
   always_comb begin
      w_ovf = 1'b0;
      if (!r_m) begin
         if (r_s == 4'h9)
            w_ovf = (w_as[SLICE_W-1] == w_bs[SLICE_W-1]) && (w_slice[SLICE_W-1] != w_as[SLICE_W-1]);
         else if (r_s == 4'h6)
            w_ovf = (w_as[SLICE_W-1] != w_bs[SLICE_W-1]) && (w_slice[SLICE_W-1] == w_bs[SLICE_W-1]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_s         <= '0;
         r_m         <= 1'b0;
         r_carry     <= 1'b0;
         r_cnt       <= '0;
         r_acc       <= '0;
         r_f         <= '0;
         r_c_out     <= 1'b0;
         r_ovf       <= 1'b0;
         r_eq        <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid && r_in_ready) begin
                  r_a        <= a;
                  r_b        <= b;
                  r_s        <= s;
                  r_m        <= m;
                  r_carry    <= c_in;
                  r_cnt      <= '0;
                  r_acc      <= '0;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= ST_CALC;
               end
            end
            ST_CALC: begin
               r_a     <= r_a >> SLICE_W;
               r_b     <= r_b >> SLICE_W;
               r_carry <= w_sum[SLICE_W];
               r_acc   <= w_acc_next;
               r_cnt   <= r_cnt + CW'(1);
               if (r_cnt == LAST) begin
                  r_f         <= w_acc_next;
                  r_c_out     <= w_c_out;
                  r_ovf       <= w_ovf;
                  r_eq        <= &w_acc_next;
                  r_out_valid <= 1'b1;
                  r_state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign f         = r_f;
   assign c_out     = r_c_out;
   assign overflow  = r_ovf;
   assign a_eq_b    = r_eq;

endmodule

// File: tb/tb_ula_serial_n_bits.sv
// Testbench for ula_serial_n_bits (WIDTH=16, SLICE_W=4): directed cases
// followed by random operations, each checked against a full-width model.
module tb_ula_serial_n_bits;

   localparam int WIDTH  = 16;
   localparam int NSLICE = 4;

   logic              clk = 1'b0;
   logic              rst_n, in_valid, in_ready, m, c_in, out_valid, out_ready;
   logic [WIDTH-1:0]  a, b, f;
   logic [3:0]        s;
   logic              c_out, overflow, a_eq_b, busy;

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic [15:0] f;
      logic        co;
      logic        ov;
      logic        eq;
   } res_t;

   always #5 clk = ~clk;

   ula_serial_n_bits #(.WIDTH(WIDTH), .SLICE_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .s(s), .m(m), .c_in(c_in),
      .out_valid(out_valid), .out_ready(out_ready), .f(f),
      .c_out(c_out), .overflow(overflow), .a_eq_b(a_eq_b), .busy(busy)
   );

   // Whole-word evaluation straight from the function tables.
   function automatic res_t model(input logic [15:0] A, input logic [15:0] B,
                                  input logic [3:0] S, input logic M, input logic CI);
      res_t        r;
      logic [15:0] X, Y;
      logic [16:0] sum;
      logic        raw;
      r = '0;
      X = '0;
      Y = '0;
      if (M) begin
         case (S)
            4'h0: r.f = ~A;        4'h1: r.f = ~(A | B);
            4'h2: r.f = ~A & B;    4'h3: r.f = 16'h0000;
            4'h4: r.f = ~(A & B);  4'h5: r.f = ~B;
            4'h6: r.f = A ^ B;     4'h7: r.f = A & ~B;
            4'h8: r.f = A & B;     4'h9: r.f = ~(A ^ B);
            4'hA: r.f = B;         4'hB: r.f = ~A | B;
            4'hC: r.f = 16'hFFFF;  4'hD: r.f = A | ~B;
            4'hE: r.f = A | B;     default: r.f = A;
         endcase
      end else begin
         case (S)
            4'h0: begin X = A;      Y = 16'hFFFF; end
            4'h1: begin X = A;      Y = A | B;    end
            4'h2: begin X = A | B;  Y = 16'hFFFF; end
            4'h3: begin X = 16'hFFFF; Y = 16'h0;  end
            4'h4: begin X = A;      Y = A & B;    end
            4'h5: begin X = A | B;  Y = A & B;    end
            4'h6: begin X = A;      Y = ~B;       end
            4'h7: begin X = A & ~B; Y = 16'hFFFF; end
            4'h8: begin X = A;      Y = A & ~B;   end
            4'h9: begin X = A;      Y = B;        end
            4'hA: begin X = A | ~B; Y = A & B;    end
            4'hB: begin X = A & B;  Y = 16'hFFFF; end
            4'hC: begin X = A;      Y = A;        end
            4'hD: begin X = A | B;  Y = A;        end
            4'hE: begin X = A | ~B; Y = A;        end
            default: begin X = A;   Y = 16'h0;    end
         endcase
         sum = {1'b0, X} + {1'b0, Y} + {16'h0, CI};
         r.f = sum[15:0];
         raw = sum[16];
         r.co = (S == 4'h0 || S == 4'h2 || S == 4'h3 || S == 4'h6 || S == 4'h7 || S == 4'hB) ? ~raw : raw;
         if (S == 4'h9)      r.ov = (A[15] == B[15]) && (r.f[15] != A[15]);
         else if (S == 4'h6) r.ov = (A[15] != B[15]) && (r.f[15] == B[15]);
      end
      r.eq = (r.f == 16'hFFFF);
      return r;
   endfunction

   task automatic chk1(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %04h expected %04h", tag, obs, exp);
      end
   endtask

   // One complete operation; 'hold' extra DONE cycles with out_ready low,
   // during which the inputs wiggle and in_valid is asserted.
   task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic [3:0] ts,
                        input logic tm, input logic tci, input int hold, input string tag);
      res_t e;
      int   lat;
      e = model(ta, tb_v, ts, tm, tci);
      @(negedge clk);
      a = ta; b = tb_v; s = ts; m = tm; c_in = tci; in_valid = 1'b1; out_ready = 1'b0;
      chk1({tag, " in_ready"}, in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = 16'($urandom); b = 16'($urandom); s = 4'($urandom); m = 1'($urandom); c_in = 1'($urandom);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk16({tag, " latency"}, 16'(lat), 16'(NSLICE));
      chk16({tag, " f"}, f, e.f);
      chk1({tag, " c_out"}, c_out, e.co);
      chk1({tag, " overflow"}, overflow, e.ov);
      chk1({tag, " a_eq_b"}, a_eq_b, e.eq);
      chk1({tag, " busy"}, busy, 1'b1);
      chk1({tag, " in_ready_done"}, in_ready, 1'b0);
      for (int i = 0; i < hold; i++) begin
         a = ~a; b = ~b; in_valid = 1'b1;
         @(posedge clk); #1;
         chk1({tag, " hold out_valid"}, out_valid, 1'b1);
         chk16({tag, " hold f"}, f, e.f);
         chk1({tag, " hold in_ready"}, in_ready, 1'b0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk1({tag, " post out_valid"}, out_valid, 1'b0);
      chk1({tag, " post in_ready"}, in_ready, 1'b1);
      chk1({tag, " post busy"}, busy, 1'b0);
      chk16({tag, " post f kept"}, f, e.f);
      if (hold > 0) begin
         @(posedge clk); #1;
         chk1({tag, " no capture"}, busy, 1'b0);
      end
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      a = 16'h1234; b = 16'h4321; s = 4'h9; m = 1'b0; c_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk1("rst in_ready", in_ready, 1'b1);
      chk1("rst out_valid", out_valid, 1'b0);
      chk1("rst busy", busy, 1'b0);
      chk16("rst f", f, 16'h0000);
      chk1("rst c_out", c_out, 1'b0);
      chk1("rst overflow", overflow, 1'b0);
      chk1("rst a_eq_b", a_eq_b, 1'b0);
      @(negedge clk);
      rst_n = 1'b1; in_valid = 1'b0;
      @(posedge clk); #1;
      chk1("rst no capture", busy, 1'b0);

      do_op(16'hFFFF, 16'h0001, 4'h9, 1'b0, 1'b0, 0, "add_wrap");
      do_op(16'h7FFF, 16'h0001, 4'h9, 1'b0, 1'b0, 0, "add_ovf");
      do_op(16'h1234, 16'h1234, 4'h6, 1'b0, 1'b0, 0, "sub_eq");
      do_op(16'h0005, 16'h0003, 4'h6, 1'b0, 1'b1, 0, "sub_cin");
      do_op(16'hAAAA, 16'h5555, 4'h6, 1'b1, 1'b1, 0, "xor_logic");
      do_op(16'h8000, 16'h0001, 4'h6, 1'b0, 1'b1, 0, "sub_ovf");
      do_op(16'h0F0F, 16'h3C3C, 4'h9, 1'b0, 1'b0, 3, "hold");

      // Reset while slice 2 is being computed.
      @(negedge clk);
      a = 16'h1111; b = 16'h2222; s = 4'h9; m = 1'b0; c_in = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk1("abort in_ready", in_ready, 1'b1);
      chk1("abort busy", busy, 1'b0);
      chk1("abort out_valid", out_valid, 1'b0);
      chk16("abort f", f, 16'h0000);
      begin
         logic seen;
         seen = 1'b0;
         for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
         end
         chk1("abort no out_valid", seen, 1'b0);
      end
      do_op(16'h1111, 16'h2222, 4'h9, 1'b0, 1'b0, 0, "after_abort");

      for (int i = 0; i < 48; i++) begin
         do_op(16'($urandom), 16'($urandom), 4'(i % 16), 1'(i / 16 % 2), 1'($urandom), 0, "rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
